rvb_bitcnt_arbiter: RTL and testbench

// - Shares one rvb_bitcnt unit between two requesters (e.g. two issue slots) via valid/ready handshakes.
// - Arbitrates requests and forwards rs1/insn bits to the unit.
// - Records the winner of every accepted request in a tag FIFO.
// - Returns each unit result to the requester that issued it, in issue order.
// - Sits between the issue logic and the bit-count unit; no arithmetic of its own.

---
 rtl/rvb_bitcnt_arbiter_if.sv | 72 +++++++
 rtl/rvb_bitcnt_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rvb_bitcnt_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvb_bitcnt_arbiter_if.sv
// ----------------------------------------------------------------------------
// rvb_bitcnt_arbiter_if
// Bundles every handshake/data signal around rvb_bitcnt_arbiter:
//   - req0_* / req1_*   : issue requests (valid/ready, rs1, insn bits 3/20/21)
//   - rsp0_* / rsp1_*   : results back to each requester (valid/ready, rd)
//   - unit_din_*        : request channel towards the shared bit-count unit
//   - unit_dout_*       : result channel coming back from the unit
// Modports:
//   - slave  : the arbiter itself
//   - master : the environment (requesters plus the bit-count unit)
// Parameter XLEN: operand/result width (32 or 64).
// ----------------------------------------------------------------------------
interface rvb_bitcnt_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_rs1;
    logic            req0_insn3;
    logic            req0_insn20;
    logic            req0_insn21;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_rs1;
    logic            req1_insn3;
    logic            req1_insn20;
    logic            req1_insn21;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_rd;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_rd;

    logic            unit_din_valid;
    logic            unit_din_ready;
    logic [XLEN-1:0] unit_din_rs1;
    logic            unit_din_insn3;
    logic            unit_din_insn20;
    logic            unit_din_insn21;
    logic            unit_dout_valid;
    logic            unit_dout_ready;
    logic [XLEN-1:0] unit_dout_rd;

    modport slave (
        input  req0_valid, req0_rs1, req0_insn3, req0_insn20, req0_insn21,
        output req0_ready,
        input  req1_valid, req1_rs1, req1_insn3, req1_insn20, req1_insn21,
        output req1_ready,
        output rsp0_valid, rsp0_rd, rsp1_valid, rsp1_rd,
        input  rsp0_ready, rsp1_ready,
        output unit_din_valid, unit_din_rs1, unit_din_insn3, unit_din_insn20, unit_din_insn21,
        input  unit_din_ready,
        input  unit_dout_valid, unit_dout_rd,
        output unit_dout_ready
    );

    modport master (
        output req0_valid, req0_rs1, req0_insn3, req0_insn20, req0_insn21,
        input  req0_ready,
        output req1_valid, req1_rs1, req1_insn3, req1_insn20, req1_insn21,
        input  req1_ready,
        input  rsp0_valid, rsp0_rd, rsp1_valid, rsp1_rd,
        output rsp0_ready, rsp1_ready,
        input  unit_din_valid, unit_din_rs1, unit_din_insn3, unit_din_insn20, unit_din_insn21,
        output unit_din_ready,
        output unit_dout_valid, unit_dout_rd,
        input  unit_dout_ready
    );
endinterface

// File: rtl/rvb_bitcnt_arbiter.sv
// ----------------------------------------------------------------------------
// rvb_bitcnt_arbiter
// Shares one rvb_bitcnt unit between two requesters. Requests are arbitrated
// (round-robin by default) and forwarded to the unit with no added latency;
// the winner of every accepted request is pushed into a 1-bit tag FIFO so that
// each unit result is routed back to the requester that issued it, in order.
// Ports:
//   clock  - single clock, all state on posedge
//   reset  - synchronous, active-high; forces every valid/ready output low
//   bus    - rvb_bitcnt_arbiter_if.slave (requests, responses, unit channels)
// Parameters:
//   XLEN   - operand width (must match the interface instance)
//   DEPTH  - requests in flight inside the unit; power of 2, >= 2
// Configuration macro:
//   RVB_BITCNT_ARB_FIXED_PRIO_EN - when defined, req0 always wins a tie
//                                  (lock behaviour unchanged).
// ----------------------------------------------------------------------------

// Simulation-only protocol checker: a unit result must never appear while no
// request is outstanding.
module rvb_bitcnt_arbiter_chk (
    input logic clock,
    input logic reset,
    input logic unit_dout_valid,
    input logic fifo_empty
);
    a_no_orphan_result: assert property (@(posedge clock) disable iff (reset)
        unit_dout_valid |-> !fifo_empty);
endmodule

module rvb_bitcnt_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic                 clock,
    input logic                 reset,
    rvb_bitcnt_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             rr_last_q, rr_last_d;
    logic             lock_q, lock_d;
    logic             lock_id_q, lock_id_d;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             head_s;
    logic             grant_s;
    logic             granted_valid_s;
    logic             din_valid_s;
    logic             dout_ready_s;
    logic             accept_s;
    logic             pop_s;
    logic [XLEN-1:0]  rs1_mux_s;

    // Tag FIFO status; the extra pointer bit separates full from empty
    always_comb begin
        fifo_empty_s = (wr_ptr_q == rd_ptr_q);
        fifo_full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        head_s       = fifo_q[rd_ptr_q[PW-1:0]];
    end

    // Grant selection; a held lock keeps the stalled requester granted
    always_comb begin
        grant_s = 1'b0;
        if (lock_q) begin
            grant_s = lock_id_q;
        end else if (bus.req0_valid && bus.req1_valid) begin
`ifdef RVB_BITCNT_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~rr_last_q;
`endif
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Issue path: forward the granted request; a full FIFO blocks issue even
    // when a pop happens in the same cycle
    always_comb begin
        granted_valid_s     = grant_s ? bus.req1_valid : bus.req0_valid;
        rs1_mux_s           = grant_s ? bus.req1_rs1   : bus.req0_rs1;
        bus.unit_din_rs1    = rs1_mux_s;
        bus.unit_din_insn3  = grant_s ? bus.req1_insn3  : bus.req0_insn3;
        bus.unit_din_insn20 = grant_s ? bus.req1_insn20 : bus.req0_insn20;
        bus.unit_din_insn21 = grant_s ? bus.req1_insn21 : bus.req0_insn21;
        if (reset) begin
            din_valid_s    = 1'b0;
            bus.req0_ready = 1'b0;
            bus.req1_ready = 1'b0;
        end else begin
            din_valid_s    = granted_valid_s & ~fifo_full_s;
            bus.req0_ready = ~grant_s & ~fifo_full_s & bus.unit_din_ready;
            bus.req1_ready =  grant_s & ~fifo_full_s & bus.unit_din_ready;
        end
        bus.unit_din_valid = din_valid_s;
        accept_s           = din_valid_s & bus.unit_din_ready;
    end

    // Return path: the FIFO head tells which requester owns the unit result
    always_comb begin
        if (reset || fifo_empty_s) begin
            bus.rsp0_valid = 1'b0;
            bus.rsp1_valid = 1'b0;
            dout_ready_s   = 1'b0;
        end else begin
            bus.rsp0_valid = ~head_s & bus.unit_dout_valid;
            bus.rsp1_valid =  head_s & bus.unit_dout_valid;
            dout_ready_s   = head_s ? bus.rsp1_ready : bus.rsp0_ready;
        end
        bus.unit_dout_ready = dout_ready_s;
        bus.rsp0_rd         = bus.unit_dout_rd;
        bus.rsp1_rd         = bus.unit_dout_rd;
        pop_s               = bus.unit_dout_valid & dout_ready_s;
    end

    // Next state: push/pop the tag FIFO, update round-robin and lock
    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rr_last_d = rr_last_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept_s) begin
            fifo_d[wr_ptr_q[PW-1:0]] = grant_s;
            wr_ptr_d  = wr_ptr_q + (PW+1)'(1);
            rr_last_d = grant_s;
            lock_d    = 1'b0;
        end else if (din_valid_s) begin
            // offered but not taken: freeze grant until the handshake
            lock_d    = 1'b1;
            lock_id_d = grant_s;
        end else begin
            lock_d    = lock_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_q    <= {DEPTH{1'b0}};
            wr_ptr_q  <= {(PW+1){1'b0}};
            rd_ptr_q  <= {(PW+1){1'b0}};
            rr_last_q <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rr_last_q <= rr_last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

`ifndef SYNTHESIS
    rvb_bitcnt_arbiter_chk u_chk (
        .clock           (clock),
        .reset           (reset),
        .unit_dout_valid (bus.unit_dout_valid),
        .fifo_empty      (fifo_empty_s)
    );
`endif
endmodule

// File: tb/tb_rvb_bitcnt_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rvb_bitcnt_arbiter
// Self-checking bench for rvb_bitcnt_arbiter (XLEN=32, DEPTH=4). The bench
// plays both requesters and the bit-count unit. A directed table and a few
// hand sequences cover arbitration, lock, full FIFO and mid-flight reset;
// randomized traffic is scored against per-requester expected-result queues.
// ----------------------------------------------------------------------------
module tb_rvb_bitcnt_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RS1_A = 32'hA0A0_A0A0;
    localparam logic [31:0] RS1_B = 32'hB1B1_B1B1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rvb_bitcnt_arbiter_if #(.XLEN(XLEN)) bus ();

    rvb_bitcnt_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic v0, v1, dr;
        logic r0, r1, dv, g, dor;
    } vec_t;
    vec_t tbl [10];

    // requester / unit model state
    logic        pend [2];
    logic [31:0] rs1_h [2];
    logic        i3_h [2];
    logic        i20_h [2];
    logic        i21_h [2];
    int          left [2];
    int          n_iss [2];
    int          n_rsp [2];
    int          p_req, p_dr, p_rr;
    logic        fixed_op;
    logic [31:0] exp0_q [$];
    logic [31:0] exp1_q [$];
    logic        order_q [$];
    logic [31:0] unit_q [$];
    int          grants_q [$];
    logic        prev_stall;
    logic [31:0] prev_rs1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // clz / ctz / cpop selected by insn bits 20/21 (32-bit forms)
    function automatic logic [31:0] ref_bitcnt(input logic [31:0] x, input logic i20, input logic i21);
        int n;
        n = 0;
        if (i21) begin
            for (int k = 0; k < 32; k++) n += int'(x[k]);
        end else if (i20) begin
            n = 32;
            for (int k = 31; k >= 0; k--) if (x[k]) n = k;
        end else begin
            n = 32;
            for (int k = 0; k < 32; k++) if (x[k]) n = 31 - k;
        end
        return 32'(n);
    endfunction

    task automatic drive_all(input logic v);
        bus.req0_valid = v; bus.req1_valid = v;
        bus.rsp0_ready = v; bus.rsp1_ready = v;
        bus.unit_din_ready = v; bus.unit_dout_valid = v;
    endtask

    task automatic chk_outputs_low(input string tag);
        chk({tag, "_req0_ready"}, 64'(bus.req0_ready), 64'd0);
        chk({tag, "_req1_ready"}, 64'(bus.req1_ready), 64'd0);
        chk({tag, "_din_valid"},  64'(bus.unit_din_valid), 64'd0);
        chk({tag, "_rsp0_valid"}, 64'(bus.rsp0_valid), 64'd0);
        chk({tag, "_rsp1_valid"}, 64'(bus.rsp1_valid), 64'd0);
        chk({tag, "_dout_ready"}, 64'(bus.unit_dout_ready), 64'd0);
    endtask

    task automatic do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            reset = 1'b1;
            drive_all(1'b1);
            #1;
            chk_outputs_low("reset");
            @(posedge clock);
        end
        @(negedge clock);
        reset = 1'b0;
        drive_all(1'b0);
        exp0_q.delete(); exp1_q.delete(); order_q.delete(); unit_q.delete(); grants_q.delete();
        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; left[n] = 0; n_iss[n] = 0; n_rsp[n] = 0;
        end
        prev_stall = 1'b0;
    endtask

    // One cycle of modelled traffic: drive, check, advance the model
    task automatic step();
        logic full, acc0, acc1, hd, fired;
        int   win;
        @(negedge clock);
        for (int n = 0; n < 2; n++) begin
            if (!pend[n] && left[n] > 0 && int'($urandom_range(99)) < p_req) begin
                pend[n] = 1'b1;
                left[n]--;
                if (fixed_op) begin
                    rs1_h[n] = 32'h0000_00FF; i3_h[n] = 1'b0; i20_h[n] = 1'b0; i21_h[n] = 1'b1;
                end else begin
                    rs1_h[n] = $urandom >> $urandom_range(31);
                    i3_h[n]  = 1'($urandom);
                    i20_h[n] = 1'($urandom);
                    i21_h[n] = 1'($urandom);
                end
            end
        end
        bus.req0_valid = pend[0]; bus.req0_rs1 = rs1_h[0];
        bus.req0_insn3 = i3_h[0]; bus.req0_insn20 = i20_h[0]; bus.req0_insn21 = i21_h[0];
        bus.req1_valid = pend[1]; bus.req1_rs1 = rs1_h[1];
        bus.req1_insn3 = i3_h[1]; bus.req1_insn20 = i20_h[1]; bus.req1_insn21 = i21_h[1];
        bus.unit_din_ready  = (int'($urandom_range(99)) < p_dr);
        bus.rsp0_ready      = (int'($urandom_range(99)) < p_rr);
        bus.rsp1_ready      = (int'($urandom_range(99)) < p_rr);
        bus.unit_dout_valid = (unit_q.size() > 0);
        bus.unit_dout_rd    = (unit_q.size() > 0) ? unit_q[0] : 32'h0;
        #1;
        full = (order_q.size() == DEPTH);
        chk("din_valid", 64'(bus.unit_din_valid), 64'(!full && (pend[0] || pend[1])));
        if (full) chk("ready_when_full", 64'(bus.req0_ready | bus.req1_ready), 64'd0);
        if (prev_stall) chk("stall_rs1_stable", 64'(bus.unit_din_rs1), 64'(prev_rs1));
        chk("rsp0_valid", 64'(bus.rsp0_valid),
            64'(unit_q.size() > 0 && order_q.size() > 0 && order_q[0] == 1'b0));
        chk("rsp1_valid", 64'(bus.rsp1_valid),
            64'(unit_q.size() > 0 && order_q.size() > 0 && order_q[0] == 1'b1));
        chk("dout_ready", 64'(bus.unit_dout_ready),
            64'(order_q.size() > 0 && (order_q[0] ? bus.rsp1_ready : bus.rsp0_ready)));
        acc0 = bus.req0_valid & bus.req0_ready;
        acc1 = bus.req1_valid & bus.req1_ready;
        if (bus.unit_din_valid && bus.unit_din_ready) begin
            chk("one_winner", 64'(int'(acc0) + int'(acc1)), 64'd1);
            win = acc1 ? 1 : 0;
            chk("din_rs1", 64'(bus.unit_din_rs1), 64'(rs1_h[win]));
            chk("din_insn", 64'({bus.unit_din_insn3, bus.unit_din_insn20, bus.unit_din_insn21}),
                64'({i3_h[win], i20_h[win], i21_h[win]}));
            order_q.push_back(win[0]);
            grants_q.push_back(win);
            unit_q.push_back(ref_bitcnt(bus.unit_din_rs1, bus.unit_din_insn20, bus.unit_din_insn21));
            if (win == 0) exp0_q.push_back(ref_bitcnt(rs1_h[0], i20_h[0], i21_h[0]));
            else          exp1_q.push_back(ref_bitcnt(rs1_h[1], i20_h[1], i21_h[1]));
            pend[win] = 1'b0;
            n_iss[win]++;
        end else begin
            chk("no_accept", 64'(acc0 | acc1), 64'd0);
        end
        if (bus.unit_dout_valid && bus.unit_dout_ready) begin
            if (order_q.size() == 0) begin
                chk("pop_when_empty", 64'(bus.unit_dout_ready), 64'd0);
            end else begin
                hd    = order_q.pop_front();
                void'(unit_q.pop_front());
                fired = hd ? (bus.rsp1_valid & bus.rsp1_ready) : (bus.rsp0_valid & bus.rsp0_ready);
                chk("rsp_fire", 64'(fired), 64'd1);
                if (hd) begin
                    chk("rsp1_rd", 64'(bus.rsp1_rd), 64'(exp1_q.pop_front()));
                    n_rsp[1]++;
                end else begin
                    if (fixed_op) chk("rsp0_cpop_ff", 64'(bus.rsp0_rd), 64'd8);
                    chk("rsp0_rd", 64'(bus.rsp0_rd), 64'(exp0_q.pop_front()));
                    n_rsp[0]++;
                end
            end
        end
        prev_stall = bus.unit_din_valid & ~bus.unit_din_ready;
        prev_rs1   = bus.unit_din_rs1;
        @(posedge clock);
    endtask

    task automatic drain();
        int c;
        left[0] = 0; left[1] = 0;
        c = 0;
        while (c < 1000 && (pend[0] || pend[1] || order_q.size() > 0)) begin
            step();
            c++;
        end
        chk("drain_done", 64'(order_q.size() + int'(pend[0]) + int'(pend[1])), 64'd0);
    endtask

    logic g_h3;

    initial begin
        drive_all(1'b0);
        bus.req0_rs1 = RS1_A; bus.req0_insn3 = 1'b0; bus.req0_insn20 = 1'b0; bus.req0_insn21 = 1'b1;
        bus.req1_rs1 = RS1_B; bus.req1_insn3 = 1'b1; bus.req1_insn20 = 1'b1; bus.req1_insn21 = 1'b0;
        bus.unit_dout_rd = 32'h0;

        //                 v0    v1    dr    r0    r1    dv    g     dor
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef RVB_BITCNT_ARB_FIXED_PRIO_EN
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef RVB_BITCNT_ARB_FIXED_PRIO_EN
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        g_h3 = 1'b0;
`else
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        g_h3 = 1'b1;
`endif
        tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        do_reset();

        // directed table: arbitration, stall lock, fill to full (no results returned)
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.req0_valid = tbl[i].v0; bus.req1_valid = tbl[i].v1;
            bus.unit_din_ready = tbl[i].dr;
            bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1; bus.unit_dout_valid = 1'b0;
            #1;
            chk($sformatf("tbl%0d_req0_ready", i), 64'(bus.req0_ready), 64'(tbl[i].r0));
            chk($sformatf("tbl%0d_req1_ready", i), 64'(bus.req1_ready), 64'(tbl[i].r1));
            chk($sformatf("tbl%0d_din_valid", i),  64'(bus.unit_din_valid), 64'(tbl[i].dv));
            chk($sformatf("tbl%0d_din_rs1", i),    64'(bus.unit_din_rs1), 64'(tbl[i].g ? RS1_B : RS1_A));
            chk($sformatf("tbl%0d_din_insn", i),
                64'({bus.unit_din_insn3, bus.unit_din_insn20, bus.unit_din_insn21}),
                64'(tbl[i].g ? 3'b110 : 3'b001));
            chk($sformatf("tbl%0d_dout_ready", i), 64'(bus.unit_dout_ready), 64'(tbl[i].dor));
            @(posedge clock);
        end

        // full FIFO held by rsp0_ready=0, then released: issue resumes a cycle later
        @(negedge clock);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.unit_din_ready = 1'b1;
        bus.unit_dout_valid = 1'b1; bus.unit_dout_rd = 32'h11;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
        #1;
        chk("full_hold_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
        chk("full_hold_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
        chk("full_hold_dout_ready", 64'(bus.unit_dout_ready), 64'd0);
        chk("full_hold_din_valid",  64'(bus.unit_din_valid), 64'd0);
        @(posedge clock);
        @(negedge clock);
        bus.rsp0_ready = 1'b1;
        #1;
        chk("full_pop_dout_ready", 64'(bus.unit_dout_ready), 64'd1);
        chk("full_pop_rsp0_rd",    64'(bus.rsp0_rd), 64'h11);
        chk("full_pop_rsp1_rd",    64'(bus.rsp1_rd), 64'h11);
        chk("full_pop_no_bypass",  64'(bus.unit_din_valid), 64'd0);
        chk("full_pop_ready",      64'(bus.req0_ready | bus.req1_ready), 64'd0);
        @(posedge clock);
        @(negedge clock);
        bus.unit_dout_valid = 1'b0; bus.unit_din_ready = 1'b0;
        #1;
        chk("resume_din_valid", 64'(bus.unit_din_valid), 64'd1);
        chk("resume_din_rs1",   64'(bus.unit_din_rs1), 64'(g_h3 ? RS1_B : RS1_A));
        chk("resume_stalled",   64'(bus.req0_ready | bus.req1_ready), 64'd0);
        @(posedge clock);

        // reset with 3 entries queued and a lock held
        @(negedge clock);
        reset = 1'b1;
        drive_all(1'b1);
        #1;
        chk_outputs_low("midreset");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus.unit_dout_valid = 1'b0; bus.req1_valid = 1'b1; bus.req0_valid = 1'b1;
        #1;
        chk("postreset_req0_ready", 64'(bus.req0_ready), 64'd1);
        chk("postreset_req1_ready", 64'(bus.req1_ready), 64'd0);
        chk("postreset_din_rs1",    64'(bus.unit_din_rs1), 64'(RS1_A));
        chk("postreset_dout_ready", 64'(bus.unit_dout_ready), 64'd0);
        chk("postreset_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        @(posedge clock);

        // single requester: 8 x cpop(0xFF) from req0
        do_reset();
        left[0] = 8; p_req = 100; p_dr = 100; p_rr = 100; fixed_op = 1'b1;
        for (int c = 0; c < 200 && n_iss[0] < 8; c++) step();
        drain();
        chk("single_rsp0_count", 64'(n_rsp[0]), 64'd8);
        chk("single_rsp1_count", 64'(n_rsp[1]), 64'd0);

        // contention: both valid every cycle
        do_reset();
        left[0] = 8; left[1] = 8; p_req = 100; p_dr = 100; p_rr = 100; fixed_op = 1'b0;
        for (int c = 0; c < 200 && grants_q.size() < 8; c++) step();
        chk("contention_grants", 64'(grants_q.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < grants_q.size(); i++) begin
`ifdef RVB_BITCNT_ARB_FIXED_PRIO_EN
            chk($sformatf("contention_grant%0d", i), 64'(grants_q[i]), 64'd0);
`else
            chk($sformatf("contention_grant%0d", i), 64'(grants_q[i]), 64'(i % 2));
`endif
        end
        drain();

        // randomized traffic with stalls on both sides
        do_reset();
        left[0] = 600; left[1] = 600; p_req = 60; p_dr = 75; p_rr = 88; fixed_op = 1'b0;
        for (int c = 0; c < 20000 && (left[0] > 0 || left[1] > 0); c++) step();
        drain();
        chk("random_rsp_total", 64'(n_rsp[0] + n_rsp[1]), 64'd1200);
        chk("random_exp_left",  64'(exp0_q.size() + exp1_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
